// File: rtl/hier_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and helpers for the hierarchical round-robin
//               arbiter: index-width helper and the wrap-scan picker.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Widest mask the generic picker accepts, and the bits needed to index it
    localparam int c_pick_w  = 64;
    localparam int c_pick_sw = 6;
    localparam int c_pick_iw = 8;

    typedef struct packed {
        logic                 found;
        logic [c_pick_iw-1:0] idx;
    } pick_t;

    // $clog2 clamped to at least one bit so single-entry ranges stay legal
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of mask[width-1:0] scanning upward from ptr with wrap.
    // The wrap is an explicit compare-and-subtract so non-power-of-two widths work.
    function automatic pick_t rr_pick(input logic [c_pick_w-1:0] mask,
                                      input int                  ptr,
                                      input int                  width);
        pick_t res;
        int    j;
        res = '0;
        for (int k = 0; k < c_pick_w; k++) begin
            if (k < width) begin
                j = ptr + k;
                if (j >= width) begin
                    j = j - width;
                end
                if (!res.found && mask[j[c_pick_sw-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = j[c_pick_iw-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hier_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : hier_rr_arbiter_if
// Description : Request/grant bundle between requesters and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface hier_rr_arbiter_if
    import arb_pkg::*;
#(
    parameter int N   = 8,
    parameter int IDW = idx_w(N)
);
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;

    modport master (output req, input grant, input grant_valid, input grant_id);
    modport slave  (input req, output grant, output grant_valid, output grant_id);
endinterface
`default_nettype wire

// File: rtl/hier_rr_arbiter_leaf.sv
`default_nettype none
// ============================================================================
// Module      : rr_leaf
// Description : Combinational round-robin picker over a WIDTH-bit mask,
//               scanning from i_ptr upward with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_leaf
    import arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PTR_W = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] i_mask,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [PTR_W-1:0] o_idx
);

    logic [c_pick_w-1:0]        w_mask_ext;
    pick_t                      w_pick;
    logic [c_pick_iw-PTR_W-1:0] w_unused_idx;

    always_comb begin
        w_mask_ext              = '0;
        w_mask_ext[WIDTH-1:0]   = i_mask;
        w_pick                  = rr_pick(w_mask_ext, int'(i_ptr), WIDTH);
    end

    assign o_valid      = w_pick.found;
    assign o_idx        = w_pick.idx[PTR_W-1:0];
    assign w_unused_idx = w_pick.idx[c_pick_iw-1:PTR_W];

endmodule
`default_nettype wire

// File: rtl/hier_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hier_rr_arbiter
// Description : Two-level (group/leaf) round-robin arbiter with registered
//               one-hot grant and MAX_HOLD-cycle preemption.
// Revision    : 1.0 - initial release
// ============================================================================
module hier_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N_GROUPS   = 2,
    parameter int GROUP_SIZE = 4,
    parameter int MAX_HOLD   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hier_rr_arbiter_if.slave      bus
);

    localparam int c_n   = N_GROUPS * GROUP_SIZE;
    localparam int c_idw = idx_w(c_n);
    localparam int c_gw  = idx_w(N_GROUPS);
    localparam int c_lw  = idx_w(GROUP_SIZE);
    localparam int c_hw  = idx_w(MAX_HOLD + 1);

    localparam logic [c_hw-1:0] c_hold_max  = c_hw'(MAX_HOLD);
    localparam logic [c_gw-1:0] c_grp_last  = c_gw'(N_GROUPS - 1);
    localparam logic [c_lw-1:0] c_leaf_last = c_lw'(GROUP_SIZE - 1);
    localparam logic [c_n-1:0]  c_grant_lsb = c_n'(1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [c_n-1:0]  r_grant;
    logic [c_idw-1:0] r_grant_id;
    logic            r_grant_valid;
    logic [c_gw-1:0] r_root_ptr;
    logic [c_lw-1:0] r_leaf_ptr [N_GROUPS];
    logic [c_hw-1:0] r_hold_cnt;

    logic [c_n-1:0]      w_cand;
    logic [c_n-1:0]      w_others;
    logic                w_arb;
    logic                w_owner_req;
    logic                w_hold_exp;
    logic [N_GROUPS-1:0] w_leaf_valid;
    logic [c_lw-1:0]     w_leaf_idx [N_GROUPS];
    logic                w_root_valid;
    logic [c_gw-1:0]     w_root_idx;
    logic [c_lw-1:0]     w_win_leaf;
    logic [c_idw-1:0]    w_win_id;
    logic                w_load;
    logic                w_hold;

    // The owner's own request bit, without indexing by grant_id
    assign w_owner_req = |(bus.req & r_grant);
    assign w_hold_exp  = (MAX_HOLD != 0) && (r_hold_cnt == c_hold_max);
    assign w_others    = bus.req & ~r_grant;

    // Candidate mask; on preemption the owner competes only when nobody else asks
    always_comb begin
        w_cand = bus.req;
        w_arb  = 1'b1;
        if (r_state == c_st_busy && w_owner_req) begin
            if (w_hold_exp) begin
                w_cand = (|w_others) ? w_others : r_grant;
            end else begin
                w_arb  = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_GROUPS; g++) begin : g_leaf
        rr_leaf #(
            .WIDTH (GROUP_SIZE),
            .PTR_W (c_lw)
        ) u_leaf (
            .i_mask  (w_cand[g*GROUP_SIZE +: GROUP_SIZE]),
            .i_ptr   (r_leaf_ptr[g]),
            .o_valid (w_leaf_valid[g]),
            .o_idx   (w_leaf_idx[g])
        );
    end

    rr_leaf #(
        .WIDTH (N_GROUPS),
        .PTR_W (c_gw)
    ) u_root (
        .i_mask  (w_leaf_valid),
        .i_ptr   (r_root_ptr),
        .o_valid (w_root_valid),
        .o_idx   (w_root_idx)
    );

    assign w_win_leaf = w_leaf_idx[w_root_idx];
    assign w_win_id   = c_idw'(int'(w_root_idx) * GROUP_SIZE + int'(w_win_leaf));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_root_valid)          w_state_nxt = c_st_busy;
            c_st_busy: if (w_arb && !w_root_valid) w_state_nxt = c_st_idle;
            default:                               w_state_nxt = c_st_idle;
        endcase
    end

    // ---------------- FSM: outputs (register controls) ----------------
    always_comb begin
        w_load = w_arb && w_root_valid;
        w_hold = (r_state == c_st_busy) && !w_arb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_hold_cnt    <= '0;
        end else if (w_load) begin
            r_grant       <= c_grant_lsb << w_win_id;
            r_grant_id    <= w_win_id;
            r_grant_valid <= 1'b1;
            r_hold_cnt    <= c_hw'(1);
        end else if (w_hold) begin
            // Saturates so an unlimited hold never wraps back into a preempt value
            if (r_hold_cnt != '1) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end else begin
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_hold_cnt    <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_root_ptr <= '0;
            for (int g = 0; g < N_GROUPS; g++) begin
                r_leaf_ptr[g] <= '0;
            end
        end else if (w_load) begin
            r_root_ptr <= (w_root_idx == c_grp_last) ? '0 : w_root_idx + 1'b1;
            r_leaf_ptr[w_root_idx] <= (w_win_leaf == c_leaf_last) ? '0 : w_win_leaf + 1'b1;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_id    = r_grant_id;
    assign bus.grant_valid = r_grant_valid;

endmodule
`default_nettype wire

// File: tb/tb_hier_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_hier_rr_arbiter
// Description : Directed + random bench for two arbiter configurations
//               (2x4 hold 4, and 3x3 unlimited) against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hier_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hier_rr_arbiter_if #(.N(8)) bus_a ();
    hier_rr_arbiter_if #(.N(9)) bus_b ();

    hier_rr_arbiter #(.N_GROUPS(2), .GROUP_SIZE(4), .MAX_HOLD(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    hier_rr_arbiter #(.N_GROUPS(3), .GROUP_SIZE(3), .MAX_HOLD(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Model: per instance owner (-1 idle), hold count and rotation pointers
    int m_ng [2] = '{2, 3};
    int m_gs [2] = '{4, 3};
    int m_mh [2] = '{4, 0};
    int m_owner [2];
    int m_hold  [2];
    int m_root  [2];
    int m_leaf  [2][3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_hold[m]  = 0;
            m_root[m]  = 0;
            for (int g = 0; g < 3; g++) m_leaf[m][g] = 0;
        end
    endtask

    function automatic int model_pick(input int m, input logic [31:0] cand);
        int g;
        int i;
        for (int gk = 0; gk < m_ng[m]; gk++) begin
            g = (m_root[m] + gk) % m_ng[m];
            for (int ik = 0; ik < m_gs[m]; ik++) begin
                i = (m_leaf[m][g] + ik) % m_gs[m];
                if (cand[g*m_gs[m] + i]) return g*m_gs[m] + i;
            end
        end
        return -1;
    endfunction

    task automatic model_step(input int m, input logic [31:0] req);
        int w;
        int g;
        if (m_owner[m] < 0 || !req[m_owner[m]]) begin
            w = model_pick(m, req);
        end else if (m_mh[m] != 0 && m_hold[m] >= m_mh[m]) begin
            w = model_pick(m, req & ~(32'd1 << m_owner[m]));
            if (w < 0) w = m_owner[m];
        end else begin
            m_hold[m]++;
            return;
        end
        if (w < 0) begin
            m_owner[m] = -1;
            m_hold[m]  = 0;
        end else begin
            g = w / m_gs[m];
            m_owner[m]   = w;
            m_hold[m]    = 1;
            m_leaf[m][g] = (w % m_gs[m] + 1) % m_gs[m];
            m_root[m]    = (g + 1) % m_ng[m];
        end
    endtask

    function automatic logic [31:0] exp_grant(input int m);
        return (m_owner[m] < 0) ? 32'd0 : (32'd1 << m_owner[m]);
    endfunction

    function automatic logic [31:0] exp_id(input int m);
        return (m_owner[m] < 0) ? 32'd0 : 32'(m_owner[m]);
    endfunction

    task automatic check_model();
        chk("a_grant", 32'(bus_a.grant), exp_grant(0));
        chk("a_id",    32'(bus_a.grant_id), exp_id(0));
        chk("a_valid", 32'(bus_a.grant_valid), 32'(m_owner[0] >= 0));
        chk("b_grant", 32'(bus_b.grant), exp_grant(1));
        chk("b_id",    32'(bus_b.grant_id), exp_id(1));
        chk("b_valid", 32'(bus_b.grant_valid), 32'(m_owner[1] >= 0));
    endtask

    // One clock: both models advance on the same request the DUTs sampled
    task automatic tick();
        @(posedge clk);
        model_step(0, 32'(bus_a.req));
        model_step(1, 32'(bus_b.req));
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bus_a.req = '0;
        bus_b.req = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_grant", 32'(bus_a.grant), 32'd0);
        chk("rst_a_valid", 32'(bus_a.grant_valid), 32'd0);
        chk("rst_b_grant", 32'(bus_b.grant), 32'd0);
        chk("rst_b_id",    32'(bus_b.grant_id), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] seq_a [8] = '{8'h01, 8'h10, 8'h02, 8'h20, 8'h04, 8'h40, 8'h08, 8'h80};
    int         ord_b [9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        bus_a.req = '0;
        bus_b.req = '0;
        model_reset();

        // Single request, then release to idle
        do_reset();
        bus_a.req = 8'h01;
        tick();
        chk("t1_grant", 32'(bus_a.grant), 32'h01);
        chk("t1_id",    32'(bus_a.grant_id), 32'd0);
        chk("t1_valid", 32'(bus_a.grant_valid), 32'd1);
        bus_a.req = 8'h00;
        tick();
        chk("t1_idle", 32'(bus_a.grant), 32'h00);

        // All requesting: interleaved group order, MAX_HOLD cycles each
        do_reset();
        bus_a.req = 8'hFF;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) begin
                for (int c = 0; c < 4; c++) begin
                    tick();
                    chk("t2_seq", 32'(bus_a.grant), 32'(seq_a[k]));
                end
            end
        end

        // Voluntary release hands over with no bubble
        do_reset();
        bus_a.req = 8'h03;
        tick();
        chk("t3_first", 32'(bus_a.grant), 32'h01);
        tick();
        bus_a.req = 8'h02;
        tick();
        chk("t3_handover", 32'(bus_a.grant), 32'h02);
        bus_a.req = 8'h00;
        tick();
        chk("t3_idle", 32'(bus_a.grant), 32'h00);

        // Lone requester survives its own preemption
        do_reset();
        bus_a.req = 8'h08;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("t4_grant", 32'(bus_a.grant), 32'h08);
            chk("t4_valid", 32'(bus_a.grant_valid), 32'd1);
        end

        // Asynchronous reset mid-grant clears outputs and pointers
        do_reset();
        bus_a.req = 8'h30;
        tick();
        chk("t5_first", 32'(bus_a.grant), 32'h10);
        bus_a.req = 8'h01;
        tick();
        chk("t5_second", 32'(bus_a.grant), 32'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_grant", 32'(bus_a.grant), 32'h00);
        chk("t5_async_valid", 32'(bus_a.grant_valid), 32'd0);
        chk("t5_async_id",    32'(bus_a.grant_id), 32'd0);
        model_reset();
        bus_a.req = 8'hFF;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        chk("t5_after_rst", 32'(bus_a.grant), 32'h01);

        // Non-power-of-two instance, each owner releasing after one cycle
        do_reset();
        bus_b.req = 9'h1FF;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("t6_order", 32'(bus_b.grant_id), 32'(ord_b[k]));
            bus_b.req = 9'h1FF & ~(9'd1 << ord_b[k]);
        end

        // Random request churn on both instances
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(7) == 0) bus_a.req[b] = ~bus_a.req[b];
            end
            for (int b = 0; b < 9; b++) begin
                if ($urandom_range(5) == 0) bus_b.req[b] = ~bus_b.req[b];
            end
            if ($urandom_range(49) == 0) bus_a.req = '0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
